debug_host_driver: RTL and testbench

- Host-side counterpart of the MIPS debug unit: drives the target's UART debug protocol from hardware.
- Streams a program from a local ROM, issues run and step commands, and receives the state dump that follows each run.
- Sits between a UART byte transceiver and a supervising controller or self-test logic; used for board-to-board bring-up and synthesizable regression.

---
 rtl/debug_host_driver.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_debug_host_driver.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_host_driver.sv
// Host-side driver for the MIPS debug unit UART protocol: streams a program from a local ROM,
// issues run/step commands and captures the state dumps. Optional rx watchdog: DEBUG_HOST_TIMEOUT_EN.
module debug_host_driver #(
  parameter int LEN        = 32,
  parameter int PROG_DEPTH = 64,
  parameter int NB_ADDR    = $clog2(PROG_DEPTH),
  parameter int HDR_BYTES  = 24,
  parameter int CANT_REGS  = 32,
  parameter int CANT_MEM   = 16,
  parameter int DUMP_BYTES = HDR_BYTES + (CANT_REGS + CANT_MEM) * 4,
`ifdef DEBUG_HOST_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 1000000,
`endif
  parameter int NB_DUMP    = $clog2(DUMP_BYTES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_code,
  output logic               cmd_ready,
  output logic               cmd_err,
  output logic [NB_ADDR-1:0] prog_addr,
  input  logic [LEN-1:0]     prog_data,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  input  logic               rx_done,
  input  logic [7:0]         rx_data,
  output logic               dump_valid,
  output logic [7:0]         dump_byte,
  output logic [NB_DUMP-1:0] dump_idx,
  output logic               dump_done,
  output logic [NB_ADDR:0]   words_loaded,
  output logic [1:0]         mode_out,
`ifdef DEBUG_HOST_TIMEOUT_EN
  output logic               timeout_err,
`endif
  output logic               busy
);

  localparam int BPW  = LEN / 8;
  localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [2:0] OP_LOAD    = 3'd0;
  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_ENTER   = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_REPROG  = 3'd4;

  localparam logic [1:0] MODE_UNLOADED = 2'd0;
  localparam logic [1:0] MODE_WAITING  = 2'd1;
  localparam logic [1:0] MODE_STEPPING = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    WAIT_TX,
    FETCH,
    SEND_BYTE,
    RX_DUMP,
    DONE
  } state_t;

  state_t               state_reg, state_next;
  state_t               ret_reg, ret_next;
  logic [1:0]           mode_reg, mode_next;
  logic [2:0]           op_reg, op_next;
  logic                 seq_reg, seq_next;
  logic [NB_ADDR-1:0]   addr_reg, addr_next;
  logic [BC_W-1:0]      byte_cnt_reg, byte_cnt_next;
  logic [LEN-1:0]       word_reg, word_next;
  logic                 term_reg, term_next;
  logic                 fetch_wait_reg, fetch_wait_next;
  logic                 tx_start_reg, tx_start_next;
  logic [7:0]           tx_data_reg, tx_data_next;
  logic                 cmd_err_reg, cmd_err_next;
  logic                 cmd_ready_reg, cmd_ready_next;
  logic                 busy_reg, busy_next;
  logic [NB_ADDR:0]     words_loaded_reg, words_loaded_next;
  logic [NB_DUMP-1:0]   dump_cnt_reg, dump_cnt_next;
  logic                 dump_valid_reg, dump_valid_next;
  logic [7:0]           dump_byte_reg, dump_byte_next;
  logic [NB_DUMP-1:0]   dump_idx_reg, dump_idx_next;
  logic                 last_pend_reg, last_pend_next;
  logic                 dump_done_reg, dump_done_next;
  logic                 legal;
`ifdef DEBUG_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]      to_cnt_reg, to_cnt_next;
  logic                 timeout_err_reg, timeout_err_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      ret_reg          <= IDLE;
      mode_reg         <= MODE_UNLOADED;
      op_reg           <= 3'd0;
      seq_reg          <= 1'b0;
      addr_reg         <= '0;
      byte_cnt_reg     <= '0;
      word_reg         <= '0;
      term_reg         <= 1'b0;
      fetch_wait_reg   <= 1'b0;
      tx_start_reg     <= 1'b0;
      tx_data_reg      <= 8'd0;
      cmd_err_reg      <= 1'b0;
      cmd_ready_reg    <= 1'b0;
      busy_reg         <= 1'b0;
      words_loaded_reg <= '0;
      dump_cnt_reg     <= '0;
      dump_valid_reg   <= 1'b0;
      dump_byte_reg    <= 8'd0;
      dump_idx_reg     <= '0;
      last_pend_reg    <= 1'b0;
      dump_done_reg    <= 1'b0;
`ifdef DEBUG_HOST_TIMEOUT_EN
      to_cnt_reg       <= '0;
      timeout_err_reg  <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      ret_reg          <= ret_next;
      mode_reg         <= mode_next;
      op_reg           <= op_next;
      seq_reg          <= seq_next;
      addr_reg         <= addr_next;
      byte_cnt_reg     <= byte_cnt_next;
      word_reg         <= word_next;
      term_reg         <= term_next;
      fetch_wait_reg   <= fetch_wait_next;
      tx_start_reg     <= tx_start_next;
      tx_data_reg      <= tx_data_next;
      cmd_err_reg      <= cmd_err_next;
      cmd_ready_reg    <= cmd_ready_next;
      busy_reg         <= busy_next;
      words_loaded_reg <= words_loaded_next;
      dump_cnt_reg     <= dump_cnt_next;
      dump_valid_reg   <= dump_valid_next;
      dump_byte_reg    <= dump_byte_next;
      dump_idx_reg     <= dump_idx_next;
      last_pend_reg    <= last_pend_next;
      dump_done_reg    <= dump_done_next;
`ifdef DEBUG_HOST_TIMEOUT_EN
      to_cnt_reg       <= to_cnt_next;
      timeout_err_reg  <= timeout_err_next;
`endif
    end
  end

  always_comb begin
    unique case (cmd_code)
      OP_LOAD:                    legal = (mode_reg == MODE_UNLOADED);
      OP_RUN, OP_ENTER, OP_REPROG: legal = (mode_reg == MODE_WAITING);
      OP_STEP:                    legal = (mode_reg == MODE_STEPPING);
      default:                    legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next        = state_reg;
    ret_next          = ret_reg;
    mode_next         = mode_reg;
    op_next           = op_reg;
    seq_next          = seq_reg;
    addr_next         = addr_reg;
    byte_cnt_next     = byte_cnt_reg;
    word_next         = word_reg;
    term_next         = term_reg;
    fetch_wait_next   = fetch_wait_reg;
    tx_start_next     = 1'b0;
    tx_data_next      = tx_data_reg;
    cmd_err_next      = 1'b0;
    words_loaded_next = words_loaded_reg;
    dump_cnt_next     = dump_cnt_reg;
    dump_valid_next   = 1'b0;
    dump_byte_next    = dump_byte_reg;
    dump_idx_next     = dump_idx_reg;
    last_pend_next    = 1'b0;
    dump_done_next    = last_pend_reg;
`ifdef DEBUG_HOST_TIMEOUT_EN
    to_cnt_next       = to_cnt_reg;
    timeout_err_next  = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          if (legal) begin
            op_next    = cmd_code;
            seq_next   = 1'b0;
            state_next = SEND_CMD;
          end else begin
            cmd_err_next = 1'b1;
          end
        end
      end

      SEND_CMD: begin
        tx_start_next = 1'b1;
        state_next    = WAIT_TX;
        // REPROGRAM prefixes 0x05 and then behaves exactly like LOAD
        if (op_reg == OP_REPROG && !seq_reg) begin
          tx_data_next = 8'h05;
          ret_next     = SEND_CMD;
          seq_next     = 1'b1;
        end else begin
          case (op_reg)
            OP_LOAD, OP_REPROG: begin
              tx_data_next    = 8'h01;
              ret_next        = FETCH;
              addr_next       = '0;
              fetch_wait_next = 1'b0;
            end
            OP_RUN: begin
              tx_data_next = 8'h02;
              ret_next     = RX_DUMP;
            end
            OP_ENTER: begin
              tx_data_next = 8'h03;
              ret_next     = DONE;
            end
            OP_STEP: begin
              tx_data_next = 8'h06;
              ret_next     = RX_DUMP;
            end
            default: begin
              tx_start_next = 1'b0;
              state_next    = DONE;
            end
          endcase
        end
      end

      WAIT_TX: begin
        if (tx_done) begin
          if (ret_reg == SEND_BYTE) begin
            if (byte_cnt_reg == BC_W'(BPW - 1)) begin
              if (term_reg || addr_reg == NB_ADDR'(PROG_DEPTH - 1)) begin
                words_loaded_next = {1'b0, addr_reg} + (NB_ADDR + 1)'(1);
                mode_next         = MODE_WAITING;
                cmd_err_next      = ~term_reg;
                state_next        = DONE;
              end else begin
                addr_next       = addr_reg + NB_ADDR'(1);
                fetch_wait_next = 1'b0;
                state_next      = FETCH;
              end
            end else begin
              byte_cnt_next = byte_cnt_reg + BC_W'(1);
              word_next     = word_reg >> 8;
              state_next    = SEND_BYTE;
            end
          end else begin
            state_next    = ret_reg;
            dump_cnt_next = '0;
`ifdef DEBUG_HOST_TIMEOUT_EN
            to_cnt_next   = '0;
`endif
            if (op_reg == OP_ENTER) begin
              mode_next = MODE_STEPPING;
            end
          end
        end
      end

      FETCH: begin
        // first cycle lets the ROM register the address, second captures its data
        if (!fetch_wait_reg) begin
          fetch_wait_next = 1'b1;
        end else begin
          fetch_wait_next = 1'b0;
          word_next       = prog_data;
          term_next       = &prog_data[LEN-1 -: 6];
          byte_cnt_next   = '0;
          state_next      = SEND_BYTE;
        end
      end

      SEND_BYTE: begin
        tx_start_next = 1'b1;
        tx_data_next  = word_reg[7:0];
        ret_next      = SEND_BYTE;
        state_next    = WAIT_TX;
      end

      RX_DUMP: begin
        if (rx_done) begin
          dump_valid_next = 1'b1;
          dump_byte_next  = rx_data;
          dump_idx_next   = dump_cnt_reg;
          dump_cnt_next   = dump_cnt_reg + NB_DUMP'(1);
          if (dump_cnt_reg == NB_DUMP'(DUMP_BYTES - 1)) begin
            last_pend_next = 1'b1;
            state_next     = DONE;
          end
        end
`ifdef DEBUG_HOST_TIMEOUT_EN
        if (rx_done) begin
          to_cnt_next = '0;
        end else if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_next = 1'b1;
          state_next       = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
`endif
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    cmd_ready_next = (state_next == IDLE);
    busy_next      = (state_next != IDLE);
  end

  assign cmd_ready    = cmd_ready_reg;
  assign cmd_err      = cmd_err_reg;
  assign prog_addr    = addr_reg;
  assign tx_start     = tx_start_reg;
  assign tx_data      = tx_data_reg;
  assign dump_valid   = dump_valid_reg;
  assign dump_byte    = dump_byte_reg;
  assign dump_idx     = dump_idx_reg;
  assign dump_done    = dump_done_reg;
  assign words_loaded = words_loaded_reg;
  assign mode_out     = mode_reg;
  assign busy         = busy_reg;
`ifdef DEBUG_HOST_TIMEOUT_EN
  assign timeout_err  = timeout_err_reg;
`endif

endmodule

// File: tb/tb_debug_host_driver.sv
// Directed bench for debug_host_driver: load, run, step, illegal commands, unterminated load,
// mid-stream reset, and the rx watchdog when DEBUG_HOST_TIMEOUT_EN is defined.
module tb_debug_host_driver;
  localparam int NB_ADDR    = 6;
  localparam int NB_DUMP    = 8;
  localparam int DUMP_BYTES = 216;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic [2:0]         cmd_code = 3'd0;
  logic               cmd_ready, cmd_err;
  logic [NB_ADDR-1:0] prog_addr;
  logic [31:0]        prog_data = 32'd0;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_done = 1'b0;
  logic               rx_done = 1'b0;
  logic [7:0]         rx_data = 8'd0;
  logic               dump_valid, dump_done;
  logic [7:0]         dump_byte;
  logic [NB_DUMP-1:0] dump_idx;
  logic [NB_ADDR:0]   words_loaded;
  logic [1:0]         mode_out;
  logic               busy;
`ifdef DEBUG_HOST_TIMEOUT_EN
  logic               timeout_err;
`endif

  always #5 clk = ~clk;

  debug_host_driver #(
    .LEN(32)
`ifdef DEBUG_HOST_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready), .cmd_err(cmd_err),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .rx_done(rx_done), .rx_data(rx_data),
    .dump_valid(dump_valid), .dump_byte(dump_byte), .dump_idx(dump_idx), .dump_done(dump_done),
    .words_loaded(words_loaded), .mode_out(mode_out),
`ifdef DEBUG_HOST_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  logic [31:0] rom [0:63];
  always @(posedge clk) prog_data <= rom[prog_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART transmitter model plus output monitors, all sampled on the falling edge
  int tx_cnt = 0, err_cnt = 0, dv_cnt = 0, dd_cnt = 0;
  int dump_bad = 0, stab_bad = 0, proto_bad = 0, cur_idx = 0, cd = 0;
  logic [7:0] tx_log [0:1023];
  logic [7:0] held = 8'd0;
  logic pend = 1'b0, last_dv = 1'b0;

  always @(negedge clk) begin
    if (tx_start && tx_done) proto_bad++;
    if (tx_done) tx_done = 1'b0;
    if (reset) begin
      pend = 1'b0;
      cd = 0;
      cur_idx = 0;
    end else if (pend) begin
      if (tx_data !== held) stab_bad++;
      if (tx_start) proto_bad++;
      cd--;
      if (cd == 0) begin
        tx_done = 1'b1;
        pend = 1'b0;
      end
    end else if (tx_start) begin
      if (tx_cnt < 1024) tx_log[tx_cnt] = tx_data;
      tx_cnt++;
      held = tx_data;
      pend = 1'b1;
      cd = 2;
    end
    if (cmd_err) err_cnt++;
    if (dump_valid) begin
      if (dump_idx !== NB_DUMP'(cur_idx) || dump_byte !== 8'(cur_idx)) dump_bad++;
      cur_idx++;
      dv_cnt++;
    end
    if (dump_done) begin
      dd_cnt++;
      if (!last_dv || cur_idx != DUMP_BYTES) dump_bad++;
      cur_idx = 0;
    end
    last_dv = dump_valid;
  end

  task automatic wait_ready(input int maxc);
    int k = 0;
    while (!cmd_ready && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_cnt < n && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic issue(input logic [2:0] code);
    wait_ready(200);
    cmd_code = code;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd %0d issued at %0t, mode_out=%0d", code, $time, mode_out);
  endtask

  task automatic feed_rx(input int n);
    for (int i = 0; i < n; i++) begin
      rx_data = 8'(i);
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic run_dump(input logic [2:0] code);
    int base;
    base = tx_cnt;
    issue(code);
    wait_tx(base + 1);
    repeat (3) @(negedge clk);
    feed_rx(DUMP_BYTES);
    wait_ready(100);
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] exp_load [0:8] = '{8'h01, 8'h05, 8'h00, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'hFC};
  int t0, t1, e0, d0, dd0, k;

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0] = 32'h20010005;
    rom[1] = 32'hFC000000;
    repeat (3) @(negedge clk);
    check("rst_outs", {cmd_ready, cmd_err, tx_start, busy, dump_valid, dump_done}, 6'd0);
    check("rst_mode", mode_out, 2'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1'b1);

    // illegal commands while UNLOADED
    t0 = tx_cnt; e0 = err_cnt;
    issue(3'd1);
    check("err_pulse_run_unloaded", cmd_err, 1'b1);
    @(negedge clk);
    issue(3'd7);
    check("err_pulse_code7", cmd_err, 1'b1);
    repeat (4) @(negedge clk);
    check("err_cnt_unloaded", err_cnt - e0, 2);
    check("no_tx_unloaded", tx_cnt - t0, 0);

    // LOAD of a two-word program
    t0 = tx_cnt; e0 = err_cnt;
    issue(3'd0);
    wait_ready(2000);
    $display("LOAD: %0d bytes sent, words_loaded=%0d", tx_cnt - t0, words_loaded);
    check("load_len", tx_cnt - t0, 9);
    for (int i = 0; i < 9; i++) check($sformatf("load_b%0d", i), tx_log[t0 + i], exp_load[i]);
    check("load_words", words_loaded, 2);
    check("load_mode", mode_out, 2'd1);
    check("load_no_err", err_cnt - e0, 0);

    // rx traffic while idle must not show up as dump bytes
    d0 = dv_cnt;
    feed_rx(3);
    repeat (3) @(negedge clk);
    check("rx_idle_ignored", dv_cnt - d0, 0);

    // RUN_CONT with a full dump
    t0 = tx_cnt; d0 = dv_cnt; dd0 = dd_cnt;
    run_dump(3'd1);
    $display("RUN_CONT: tx=0x%0h dump bytes=%0d dumps=%0d", tx_log[t0], dv_cnt - d0, dd_cnt - dd0);
    check("run_tx", tx_log[t0], 8'h02);
    check("run_tx_len", tx_cnt - t0, 1);
    check("run_dv", dv_cnt - d0, DUMP_BYTES);
    check("run_dd", dd_cnt - dd0, 1);
    check("run_mode", mode_out, 2'd1);

    // ENTER_STEP then two STEPs
    t0 = tx_cnt; dd0 = dd_cnt;
    issue(3'd2);
    wait_ready(200);
    repeat (2) @(negedge clk);
    check("enter_tx", tx_log[t0], 8'h03);
    check("enter_mode", mode_out, 2'd2);
    check("enter_no_dump", dd_cnt - dd0, 0);
    t0 = tx_cnt; d0 = dv_cnt;
    run_dump(3'd3);
    run_dump(3'd3);
    $display("STEP x2: tx=0x%0h,0x%0h dumps=%0d", tx_log[t0], tx_log[t0 + 1], dd_cnt - dd0);
    check("step_tx0", tx_log[t0], 8'h06);
    check("step_tx1", tx_log[t0 + 1], 8'h06);
    check("step_dv", dv_cnt - d0, 2 * DUMP_BYTES);
    check("step_dd", dd_cnt - dd0, 2);
    check("step_mode", mode_out, 2'd2);
    check("dump_content", dump_bad, 0);

    // LOAD while STEPPING is illegal
    t0 = tx_cnt; e0 = err_cnt;
    issue(3'd0);
    check("err_pulse_load_step", cmd_err, 1'b1);
    repeat (5) @(negedge clk);
    check("err_cnt_step", err_cnt - e0, 1);
    check("no_tx_step", tx_cnt - t0, 0);

    // unterminated program fills the whole ROM
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rom[0] = 32'h0;
    rom[1] = 32'h0;
    t0 = tx_cnt; e0 = err_cnt;
    issue(3'd0);
    wait_ready(6000);
    repeat (2) @(negedge clk);
    $display("LOAD no terminator: %0d bytes, words_loaded=%0d", tx_cnt - t0, words_loaded);
    check("noterm_len", tx_cnt - t0, 257);
    check("noterm_first", tx_log[t0], 8'h01);
    check("noterm_last", tx_log[t0 + 256], 8'h00);
    check("noterm_err", err_cnt - e0, 1);
    check("noterm_words", words_loaded, 64);
    check("noterm_mode", mode_out, 2'd1);

    // REPROGRAM interrupted by reset at the third byte
    t0 = tx_cnt;
    issue(3'd4);
    wait_tx(t0 + 3);
    #2 reset = 1'b1;
    #1;
    check("reprog_b0", tx_log[t0], 8'h05);
    check("reprog_b1", tx_log[t0 + 1], 8'h01);
    check("rst_mid_outs", {tx_start, busy, cmd_ready, cmd_err}, 4'd0);
    check("rst_mid_mode", mode_out, 2'd0);
    check("rst_mid_words", words_loaded, 0);
    @(negedge clk);
    reset = 1'b0;
    t1 = tx_cnt;
    repeat (40) @(negedge clk);
    check("no_tx_after_rst", tx_cnt - t1, 0);
    check("ready_after_mid_rst", cmd_ready, 1'b1);

`ifdef DEBUG_HOST_TIMEOUT_EN
    rom[0] = 32'hFC000000;
    issue(3'd0);
    wait_ready(500);
    t0 = tx_cnt; dd0 = dd_cnt;
    issue(3'd1);
    wait_tx(t0 + 1);
    repeat (3) @(negedge clk);
    feed_rx(10);
    k = 2;
    while (!timeout_err && k < 400) begin
      @(negedge clk);
      k++;
    end
    $display("timeout: pulse %0d cycles after last rx_done", k - 1);
    check("timeout_delay", k - 1, 100);
    @(negedge clk);
    check("timeout_no_done", dd_cnt - dd0, 0);
    check("timeout_ready", cmd_ready, 1'b1);
    check("timeout_mode", mode_out, 2'd1);
`endif

    check("tx_data_stable", stab_bad, 0);
    check("tx_handshake", proto_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

endmodule
